// File: rtl/fp_pkg.sv
// Shared IEEE-754 unpack types: operand class codes, default field widths, word-width helper.
// No logic; no latency; no flow control.
// Imported by the field decoder and the unpack stage.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        DENORM = 3'd1,
        NORMAL = 3'd2,
        INF    = 3'd3,
        QNAN   = 3'd4,
        SNAN   = 3'd5
    } fp_class_t;

    function automatic int fp_word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fp_field_decode.sv
// Splits one IEEE-754 word into sign, effective exponent, significand with hidden bit, and class.
// Purely combinational, zero latency.
// No flow control; the enclosing stage owns the handshake.
module fp_field_decode
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    localparam int W = fp_word_w(EXP_W, MAN_W)
) (
    input  logic [W-1:0]     word,
    output logic             sign,
    output logic [EXP_W-1:0] exp_eff,
    output logic [MAN_W:0]   sig,
    output fp_class_t        cls
);

    logic [EXP_W-1:0] exp_fld;
    logic [MAN_W-1:0] man_fld;
    logic             exp_zero;
    logic             exp_ones;
    logic             man_zero;

    assign {sign, exp_fld, man_fld} = word;
    assign exp_zero = (exp_fld == '0);
    assign exp_ones = &exp_fld;
    assign man_zero = (man_fld == '0);

    // Denormals share the scale of the smallest normal, hence exponent 1.
    assign exp_eff = (exp_zero && !man_zero) ? EXP_W'(1) : exp_fld;
    assign sig     = {!exp_zero, man_fld};

    always_comb begin
        cls = NORMAL;
        if (exp_zero) begin
            cls = man_zero ? ZERO : DENORM;
        end else if (exp_ones) begin
            if (man_zero)
                cls = INF;
            else if (man_fld[MAN_W-1])
                cls = QNAN;
            else
                cls = SNAN;
        end
    end

endmodule

// File: rtl/fp_unpack_stage.sv
// FP adder front end: decodes both operands, orders them by magnitude, registers the result.
// Latency: one cycle from input transfer to out_valid; one pair per cycle while out_ready=1.
// Backpressure: two-entry skid buffer (output + skid register); in_ready is the registered skid-empty flag.
module fp_unpack_stage
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    localparam int W = fp_word_w(EXP_W, MAN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_big,
    output logic             sign_small,
    output logic [EXP_W-1:0] exp_big,
    output logic [EXP_W-1:0] exp_small,
    output logic [MAN_W:0]   sig_big,
    output logic [MAN_W:0]   sig_small,
    output logic [EXP_W-1:0] exp_diff,
    output logic             swapped,
    output fp_class_t        cls_a,
    output fp_class_t        cls_b,
    output logic             any_nan,
    output logic             any_inf
);

    typedef struct packed {
        logic             sign_big;
        logic             sign_small;
        logic [EXP_W-1:0] exp_big;
        logic [EXP_W-1:0] exp_small;
        logic [MAN_W:0]   sig_big;
        logic [MAN_W:0]   sig_small;
        logic [EXP_W-1:0] exp_diff;
        logic             swapped;
        fp_class_t        cls_a;
        fp_class_t        cls_b;
        logic             any_nan;
        logic             any_inf;
    } unpack_dat_t;

    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W:0]   sig_a, sig_b;
    fp_class_t        dec_cls_a, dec_cls_b;
    logic             b_gt;
    unpack_dat_t      nxt_dat;

    fp_field_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_a (
        .word(a), .sign(sign_a), .exp_eff(exp_a), .sig(sig_a), .cls(dec_cls_a)
    );

    fp_field_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_b (
        .word(b), .sign(sign_b), .exp_eff(exp_b), .sig(sig_b), .cls(dec_cls_b)
    );

    // Ties keep A as the big operand so equal magnitudes never report a swap.
    assign b_gt = ({exp_b, sig_b} > {exp_a, sig_a});

    always_comb begin
        nxt_dat            = '0;
        nxt_dat.swapped    = b_gt;
        nxt_dat.sign_big   = b_gt ? sign_b : sign_a;
        nxt_dat.sign_small = b_gt ? sign_a : sign_b;
        nxt_dat.exp_big    = b_gt ? exp_b  : exp_a;
        nxt_dat.exp_small  = b_gt ? exp_a  : exp_b;
        nxt_dat.sig_big    = b_gt ? sig_b  : sig_a;
        nxt_dat.sig_small  = b_gt ? sig_a  : sig_b;
        nxt_dat.exp_diff   = nxt_dat.exp_big - nxt_dat.exp_small;
        nxt_dat.cls_a      = dec_cls_a;
        nxt_dat.cls_b      = dec_cls_b;
        nxt_dat.any_nan    = (dec_cls_a inside {QNAN, SNAN}) || (dec_cls_b inside {QNAN, SNAN});
        nxt_dat.any_inf    = (dec_cls_a == INF) || (dec_cls_b == INF);
    end

    logic        out_vld, skid_vld;
    unpack_dat_t out_dat, skid_dat;
    logic        in_xfer, out_xfer;

    assign in_ready  = !skid_vld;
    assign out_valid = out_vld;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_vld && out_ready;

    // With the skid full in_ready is low, so a drain never coincides with a new input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_dat  <= '0;
            skid_dat <= '0;
        end else if (!out_vld || out_xfer) begin
            if (skid_vld) begin
                out_dat  <= skid_dat;
                skid_vld <= 1'b0;
            end else if (in_xfer) begin
                out_dat <= nxt_dat;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_dat <= nxt_dat;
            skid_vld <= 1'b1;
        end
    end

    assign sign_big   = out_dat.sign_big;
    assign sign_small = out_dat.sign_small;
    assign exp_big    = out_dat.exp_big;
    assign exp_small  = out_dat.exp_small;
    assign sig_big    = out_dat.sig_big;
    assign sig_small  = out_dat.sig_small;
    assign exp_diff   = out_dat.exp_diff;
    assign swapped    = out_dat.swapped;
    assign cls_a      = out_dat.cls_a;
    assign cls_b      = out_dat.cls_b;
    assign any_nan    = out_dat.any_nan;
    assign any_inf    = out_dat.any_inf;

endmodule

// File: tb/tb_fp_unpack_stage.sv
// Bench for fp_unpack_stage: known-answer table, backpressure, streaming, random handshake, reset flush.
// Expected results are queued when a pair is accepted and compared when the DUT hands a result downstream.
module tb_fp_unpack_stage;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sign_big, sign_small, swapped, any_nan, any_inf;
    logic [7:0]  exp_big, exp_small, exp_diff;
    logic [23:0] sig_big, sig_small;
    fp_class_t   cls_a, cls_b;

    fp_unpack_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sign_big(sign_big), .sign_small(sign_small), .exp_big(exp_big), .exp_small(exp_small),
        .sig_big(sig_big), .sig_small(sig_small), .exp_diff(exp_diff), .swapped(swapped),
        .cls_a(cls_a), .cls_b(cls_b), .any_nan(any_nan), .any_inf(any_inf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sb, ss;
        logic [7:0]  eb, es;
        logic [23:0] gb, gs;
        logic [7:0]  ed;
        logic        sw;
        logic [2:0]  ca, cb;
        logic        an, ai;
    } res_t;

    typedef struct {
        logic [31:0] a, b;
        res_t        r;
        string       nm;
    } vec_t;

    typedef struct {
        res_t  r;
        string nm;
    } sb_ent_t;

    int      tests = 0, fails = 0;
    int      out_cnt = 0;
    int      cyc = 0;
    sb_ent_t sb_q[$];
    sb_ent_t cur;
    vec_t    tbl[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic res_t mkr(input logic sb, ss, input logic [7:0] eb, es,
                                 input logic [23:0] gb, gs, input logic [7:0] ed,
                                 input logic sw, input logic [2:0] ca, cb, input logic an, ai);
        return {sb, ss, eb, es, gb, gs, ed, sw, ca, cb, an, ai};
    endfunction

    function automatic res_t dut_res();
        return {sign_big, sign_small, exp_big, exp_small, sig_big, sig_small,
                exp_diff, swapped, cls_a, cls_b, any_nan, any_inf};
    endfunction

    // Golden model written from the IEEE-754 field definitions.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] w[2];
        logic [7:0]  ee[2];
        logic [23:0] sg[2];
        logic [2:0]  cl[2];
        logic        big;
        res_t        r;
        w[0] = x;
        w[1] = y;
        for (int i = 0; i < 2; i++) begin
            logic [7:0]  e;
            logic [22:0] m;
            e = w[i][30:23];
            m = w[i][22:0];
            case (e)
                8'h00:   cl[i] = (m == 0) ? ZERO : DENORM;
                8'hFF:   cl[i] = (m == 0) ? INF : (m[22] ? QNAN : SNAN);
                default: cl[i] = NORMAL;
            endcase
            ee[i] = (cl[i] == DENORM) ? 8'd1 : e;
            sg[i] = (e == 0) ? {1'b0, m} : {1'b1, m};
        end
        big  = (ee[1] > ee[0]) || ((ee[1] == ee[0]) && (sg[1] > sg[0]));
        r.sw = big;
        r.sb = big ? w[1][31] : w[0][31];
        r.ss = big ? w[0][31] : w[1][31];
        r.eb = big ? ee[1] : ee[0];
        r.es = big ? ee[0] : ee[1];
        r.gb = big ? sg[1] : sg[0];
        r.gs = big ? sg[0] : sg[1];
        r.ed = r.eb - r.es;
        r.ca = cl[0];
        r.cb = cl[1];
        r.an = (cl[0] == QNAN) || (cl[0] == SNAN) || (cl[1] == QNAN) || (cl[1] == SNAN);
        r.ai = (cl[0] == INF) || (cl[1] == INF);
        return r;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0: x[30:23] = 8'h00;
            1: x[30:23] = 8'hFF;
            2: x[22:0]  = '0;
            default: ;
        endcase
        return x;
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y, input string nm);
        int guard = 0;
        a = x;
        b = y;
        cur.nm = nm;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check({nm, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("drain_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, n0;
        tbl[0] = '{32'h3F800000, 32'h40000000, mkr(0,0,8'h80,8'h7F,24'h800000,24'h800000,8'h01,1,NORMAL,NORMAL,0,0), "hidden_swap"};
        tbl[1] = '{32'h00000001, 32'h80000001, mkr(0,1,8'h01,8'h01,24'h000001,24'h000001,8'h00,0,DENORM,DENORM,0,0), "denorm_equal"};
        tbl[2] = '{32'h7F800000, 32'h7FC00000, mkr(0,0,8'hFF,8'hFF,24'hC00000,24'h800000,8'h00,1,INF,QNAN,1,1), "inf_qnan"};
        tbl[3] = '{32'h7F800001, 32'h00000000, mkr(0,0,8'hFF,8'h00,24'h800001,24'h000000,8'hFF,0,SNAN,ZERO,1,0), "snan_zero"};
        tbl[4] = '{32'h7F7FFFFF, 32'h00000000, mkr(0,0,8'hFE,8'h00,24'hFFFFFF,24'h000000,8'hFE,0,NORMAL,ZERO,0,0), "max_diff"};
        tbl[5] = '{32'h00000000, 32'h7F7FFFFF, mkr(0,0,8'hFE,8'h00,24'hFFFFFF,24'h000000,8'hFE,1,ZERO,NORMAL,0,0), "max_diff_swap"};
        tbl[6] = '{32'hC0490FDB, 32'h40490FDB, mkr(1,0,8'h80,8'h80,24'hC90FDB,24'hC90FDB,8'h00,0,NORMAL,NORMAL,0,0), "equal_sign"};
        tbl[7] = '{32'h3F800001, 32'h3F800002, mkr(0,0,8'h7F,8'h7F,24'h800002,24'h800001,8'h00,1,NORMAL,NORMAL,0,0), "mant_swap"};
        tbl[8] = '{32'h00800000, 32'h007FFFFF, mkr(0,0,8'h01,8'h01,24'h800000,24'h7FFFFF,8'h00,0,NORMAL,DENORM,0,0), "norm_vs_denorm"};
        tbl[9] = '{32'hFF800000, 32'hFFBFFFFF, mkr(1,1,8'hFF,8'hFF,24'hBFFFFF,24'h800000,8'h00,1,INF,SNAN,1,1), "ninf_snan"};

        fork
            forever begin
                sb_ent_t e;
                @(negedge clk);
                if (rst_n) begin
                    if (out_valid && out_ready) begin
                        out_cnt++;
                        if (sb_q.size() == 0) begin
                            check("unexpected_output", dut_res(), 0);
                        end else begin
                            e = sb_q.pop_front();
                            check(e.nm, dut_res(), e.r);
                        end
                    end
                    if (in_valid && in_ready) sb_q.push_back(cur);
                end
            end
        join_none

        // Reset state
        #1;
        check("reset_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid_rel", out_valid, 0);
        check("reset_data", dut_res(), 0);

        // Known-answer table, back to back
        for (int i = 0; i < 10; i++) begin
            cur.r = tbl[i].r;
            send(tbl[i].a, tbl[i].b, tbl[i].nm);
            check({tbl[i].nm, "_latency"}, out_valid, 1);
        end
        drain();

        // Backpressure: two pairs fill output and skid registers
        out_ready = 1'b0;
        cur.r = model(32'h40400000, 32'hBF000000);
        send(32'h40400000, 32'hBF000000, "bp_p1");
        cur.r = model(32'h00000003, 32'h3F7FFFFF);
        send(32'h00000003, 32'h3F7FFFFF, "bp_p2");
        check("bp_in_ready_full", in_ready, 0);
        check("bp_out_valid_full", out_valid, 1);
        @(posedge clk);
        #1;
        check("bp_in_ready_hold", in_ready, 0);
        n0 = out_cnt;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_p2_valid_next", out_valid, 1);
        check("bp_in_ready_back", in_ready, 1);
        @(posedge clk);
        #1;
        check("bp_empty_after", out_valid, 0);
        check("bp_out_count", out_cnt - n0, 2);

        // Streaming at full rate
        c0 = cyc;
        n0 = out_cnt;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] x, y;
            x = rnd_word();
            y = rnd_word();
            cur.r = model(x, y);
            send(x, y, "stream");
        end
        check("stream_cycles", cyc - c0, 100);
        @(negedge clk);
        #1;
        check("stream_out_count", out_cnt - n0, 100);
        drain();

        // Random valid/ready traffic
        for (int c = 0; c < 300; c++) begin
            logic acc;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                a = rnd_word();
                b = rnd_word();
                cur.r = model(a, b);
                cur.nm = "random";
                in_valid = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        drain();

        // Reset with both entries occupied
        out_ready = 1'b0;
        cur.r = model(32'h41200000, 32'h3DCCCCCD);
        send(32'h41200000, 32'h3DCCCCCD, "rst_p1");
        cur.r = model(32'hC1200000, 32'h00000010);
        send(32'hC1200000, 32'h00000010, "rst_p2");
        check("rst_pre_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        sb_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("rst_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        cur.r = model(32'h3F800000, 32'hBF800000);
        send(32'h3F800000, 32'hBF800000, "rst_after");
        check("rst_after_valid", out_valid, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
